// File: rtl/inputc.sv
// Router input channel: per-VC flit FIFOs and packet FSMs (route compute, active, idle).
// Head flits are offered to the switch allocator with an XY-routed output-port one-hot.
module inputc #(
   parameter logic [7:0] ROUTERID = 8'h00,
   parameter int         PCHID    = 0,
   parameter int         VCH_N    = 2,
   parameter int         DATA_W   = 32,
   parameter int         FIFO_D   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [((VCH_N > 1) ? $clog2(VCH_N) : 1)-1:0] in_vch,
   input  logic [DATA_W-1:0]           in_data,
   input  logic [VCH_N-1:0]            grant_i,
   output logic [VCH_N-1:0]            req_o,
   output logic [VCH_N*5-1:0]          port_o,
   output logic [VCH_N*DATA_W-1:0]     flit_o,
   output logic [VCH_N-1:0]            ack_o,
   output logic [VCH_N-1:0]            lck_o,
   output logic                        err_o
);

   localparam int VW       = (VCH_N > 1) ? $clog2(VCH_N) : 1;
   localparam int PW       = $clog2(FIFO_D);
   localparam int CW       = PW + 1;
   localparam int TAIL_BIT = DATA_W - 1;
   localparam int HEAD_BIT = DATA_W - 2;
   localparam logic [3:0] MY_X = ROUTERID[3:0];
   localparam logic [3:0] MY_Y = ROUTERID[7:4];

   if (FIFO_D < 2 || (FIFO_D & (FIFO_D - 1)) != 0 || PCHID < 0) begin : g_bad_param
      $error("inputc: FIFO_D must be a power of two >= 2 and PCHID non-negative");
   end

   typedef enum logic [1:0] {IDLE, RC, ACTIVE} state_t;

   logic [DATA_W-1:0] mem    [VCH_N][FIFO_D];
   logic [PW-1:0]     rd_ptr [VCH_N];
   logic [PW-1:0]     wr_ptr [VCH_N];
   logic [CW-1:0]     count  [VCH_N];
   state_t            state  [VCH_N];
   logic [4:0]        route  [VCH_N];
   logic [DATA_W-1:0] head   [VCH_N];

   logic [VCH_N-1:0] nonempty, hit, wr, drop, discard, granted, pop;

   // XY dimension-order routing: resolve X first, then Y, else deliver locally
   function automatic logic [4:0] xy_route(input logic [DATA_W-1:0] f);
      logic [3:0] dx, dy;
      logic [4:0] r;
      dx = f[3:0];
      dy = f[7:4];
      if (dx > MY_X)      r = 5'b00100;
      else if (dx < MY_X) r = 5'b10000;
      else if (dy > MY_Y) r = 5'b00010;
      else if (dy < MY_Y) r = 5'b01000;
      else                r = 5'b00001;
      return r;
   endfunction

   always_comb begin
      nonempty = '0;
      hit      = '0;
      wr       = '0;
      drop     = '0;
      discard  = '0;
      granted  = '0;
      pop      = '0;
      req_o    = '0;
      port_o   = '0;
      flit_o   = '0;
      for (int v = 0; v < VCH_N; v++) begin
         head[v]     = mem[v][rd_ptr[v]];
         nonempty[v] = (count[v] != '0);
         flit_o[v*DATA_W +: DATA_W] = nonempty[v] ? head[v] : '0;
         req_o[v]    = (state[v] == ACTIVE) && nonempty[v];
         port_o[v*5 +: 5] = (state[v] == ACTIVE) ? route[v] : 5'b0;
         // BODY/TAIL with no open packet is an orphan and gets flushed
         discard[v]  = (state[v] == IDLE) && nonempty[v] && !head[v][HEAD_BIT];
         granted[v]  = grant_i[v] && req_o[v];
         pop[v]      = discard[v] || granted[v];
         hit[v]      = in_valid && (in_vch == VW'(v));
         // a pop in the same cycle frees the slot, so a full FIFO still accepts
         wr[v]       = hit[v] && ((count[v] != CW'(FIFO_D)) || pop[v]);
         drop[v]     = hit[v] && !wr[v];
      end
   end

   always_ff @(posedge clk) begin
      for (int v = 0; v < VCH_N; v++) begin
         if (wr[v]) mem[v][wr_ptr[v]] <= in_data;
         if (state[v] == RC) route[v] <= xy_route(head[v]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < VCH_N; v++) begin
            rd_ptr[v] <= '0;
            wr_ptr[v] <= '0;
            count[v]  <= '0;
            state[v]  <= IDLE;
         end
         ack_o <= '0;
         lck_o <= '0;
         err_o <= 1'b0;
      end else begin
         ack_o <= pop;
         if (|(drop | discard)) err_o <= 1'b1;
         for (int v = 0; v < VCH_N; v++) begin
            if (wr[v])  wr_ptr[v] <= wr_ptr[v] + PW'(1);
            if (pop[v]) rd_ptr[v] <= rd_ptr[v] + PW'(1);
            if (wr[v] && !pop[v])      count[v] <= count[v] + CW'(1);
            else if (!wr[v] && pop[v]) count[v] <= count[v] - CW'(1);
            case (state[v])
               IDLE: begin
                  if (nonempty[v] && head[v][HEAD_BIT]) begin
                     state[v] <= RC;
                     lck_o[v] <= 1'b1;
                  end
               end
               RC: state[v] <= ACTIVE;
               ACTIVE: begin
                  if (granted[v] && head[v][TAIL_BIT]) begin
                     state[v] <= IDLE;
                     lck_o[v] <= 1'b0;
                  end
               end
               default: state[v] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inputc.sv
// Bench for inputc: directed scenarios plus random traffic, all compared against
// a queue-based packet model evaluated once per clock edge.
module tb_inputc;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [0:0]  in_vch = '0;
   logic [31:0] in_data = '0;
   logic [1:0]  grant_i = '0;
   logic [1:0]  req_o, ack_o, lck_o;
   logic [9:0]  port_o;
   logic [63:0] flit_o;
   logic        err_o;

   int errors = 0;
   int checks = 0;

   inputc #(.ROUTERID(8'h11), .PCHID(0), .VCH_N(2), .DATA_W(32), .FIFO_D(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vch(in_vch), .in_data(in_data),
      .grant_i(grant_i), .req_o(req_o), .port_o(port_o), .flit_o(flit_o),
      .ack_o(ack_o), .lck_o(lck_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- reference model ----------------
   logic [31:0] mq [2][$];
   int          mst [2];      // 0 idle, 1 route compute, 2 active
   logic [4:0]  mrt [2];
   logic [1:0]  mack;
   logic        merr;

   function automatic logic [4:0] xy(input logic [31:0] f);
      int dx, dy;
      dx = int'(f[3:0]);
      dy = int'(f[7:4]);
      if (dx > 1) return 5'b00100;
      if (dx < 1) return 5'b10000;
      if (dy > 1) return 5'b00010;
      if (dy < 1) return 5'b01000;
      return 5'b00001;
   endfunction

   function automatic void model_reset();
      for (int v = 0; v < 2; v++) begin
         mq[v].delete();
         mst[v] = 0;
         mrt[v] = 5'b0;
      end
      mack = 2'b0;
      merr = 1'b0;
   endfunction

   function automatic logic [1:0] mreq();
      logic [1:0] r;
      for (int v = 0; v < 2; v++) r[v] = (mst[v] == 2) && (mq[v].size() > 0);
      return r;
   endfunction

   function automatic logic [16:0] exp_ctl();
      logic [9:0] p;
      logic [1:0] l;
      for (int v = 0; v < 2; v++) begin
         p[v*5 +: 5] = (mst[v] == 2) ? mrt[v] : 5'b0;
         l[v] = (mst[v] != 0);
      end
      return {mreq(), p, mack, l, merr};
   endfunction

   function automatic logic [63:0] exp_flit();
      logic [63:0] f;
      for (int v = 0; v < 2; v++) f[v*32 +: 32] = (mq[v].size() > 0) ? mq[v][0] : 32'h0;
      return f;
   endfunction

   function automatic void model_step(input logic vld, input logic ch, input logic [31:0] d,
                                      input logic [1:0] g);
      logic [1:0]  pop;
      logic [31:0] hd;
      pop = 2'b0;
      for (int v = 0; v < 2; v++) begin
         if (mq[v].size() > 0) begin
            hd = mq[v][0];
            if (mst[v] == 0) begin
               if (hd[30]) mst[v] = 1;
               else begin
                  pop[v] = 1'b1;
                  merr = 1'b1;
               end
            end else if (mst[v] == 1) begin
               mrt[v] = xy(hd);
               mst[v] = 2;
            end else if (g[v]) begin
               pop[v] = 1'b1;
               if (hd[31]) mst[v] = 0;
            end
         end
      end
      for (int v = 0; v < 2; v++) if (pop[v]) void'(mq[v].pop_front());
      if (vld) begin
         if (mq[ch].size() < 4) mq[ch].push_back(d);
         else merr = 1'b1;
      end
      mack = pop;
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] mk(input logic [1:0] t, input logic [7:0] dst, input int tag);
      return {t, 22'(tag), dst};
   endfunction

   task automatic cyc(input logic vld, input logic ch, input logic [31:0] d, input logic [1:0] g);
      in_valid = vld;
      in_vch   = ch;
      in_data  = d;
      grant_i  = g;
      @(posedge clk);
      model_step(vld, ch, d, g);
      #1;
      in_valid = 1'b0;
      grant_i  = 2'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      grant_i  = 2'b0;
      in_vch   = '0;
      in_data  = '0;
      rst_n    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      if ({req_o, port_o, ack_o, lck_o, err_o} !== 17'h0) begin
         errors++;
         $display("FAIL reset_ctl got %h want 0", {req_o, port_o, ack_o, lck_o, err_o});
      end
      checks++;
      if (flit_o !== 64'h0) begin
         errors++;
         $display("FAIL reset_flit got %h want 0", flit_o);
      end
      checks++;
   endtask

   task automatic test_headtail();
      int first_req = -1;
      int acks = 0;
      logic [4:0] seen_port = 5'b0;
      logic lck_seen = 1'b0;
      do_reset();
      cyc(1'b1, 1'b0, mk(2'b11, 8'h11, 7), 2'b00);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b0, 32'h0, mreq());
         if ({req_o, port_o, ack_o, lck_o, err_o} !== exp_ctl()) begin
            errors++;
            $display("FAIL ht_ctl i=%0d got %h want %h", i, {req_o, port_o, ack_o, lck_o, err_o}, exp_ctl());
         end
         checks++;
         if (req_o[0] && first_req < 0) first_req = i;
         if (req_o[0]) seen_port = port_o[4:0];
         if (lck_o[0]) lck_seen = 1'b1;
         acks += int'(ack_o[0]);
      end
      if (first_req !== 1) begin
         errors++;
         $display("FAIL ht_latency got cycle %0d want 1 (2 edges after write)", first_req);
      end
      checks++;
      if (seen_port !== 5'b00001) begin
         errors++;
         $display("FAIL ht_port got %b want 00001", seen_port);
      end
      checks++;
      if (acks !== 1 || !lck_seen || lck_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL ht_ack_lck got acks=%0d lck_seen=%b lck=%b want 1,1,0", acks, lck_seen, lck_o[0]);
      end
      checks++;
   endtask

   task automatic test_packet_east();
      int acks = 0;
      logic [1:0] ty [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
      logic [4:0] seen_port = 5'b0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         if (i < 4) cyc(1'b1, 1'b1, mk(ty[i], 8'h13, i), 2'b10);
         else       cyc(1'b0, 1'b1, 32'h0, 2'b10);
         if ({req_o, port_o, ack_o, lck_o, err_o} !== exp_ctl() || flit_o !== exp_flit()) begin
            errors++;
            $display("FAIL east_cyc i=%0d got %h/%h want %h/%h", i, {req_o, port_o, ack_o, lck_o, err_o}, flit_o, exp_ctl(), exp_flit());
         end
         checks++;
         if (req_o[1]) seen_port = port_o[9:5];
         acks += int'(ack_o[1]);
      end
      if (acks !== 4 || seen_port !== 5'b00100 || lck_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL east_sum got acks=%0d port=%b lck=%b want 4,00100,0", acks, seen_port, lck_o[1]);
      end
      checks++;
   endtask

   task automatic test_overflow();
      int acks = 0;
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, mk((i == 0) ? 2'b01 : 2'b00, 8'h11, 16 + i), 2'b00);
      if (err_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_err got %b want 1", err_o);
      end
      checks++;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0, 32'h0, (i >= 2) ? 2'b01 : 2'b00);
         if ({req_o, port_o, ack_o, lck_o, err_o} !== exp_ctl() || flit_o !== exp_flit()) begin
            errors++;
            $display("FAIL ovf_cyc i=%0d got %h/%h want %h/%h", i, {req_o, port_o, ack_o, lck_o, err_o}, flit_o, exp_ctl(), exp_flit());
         end
         checks++;
         acks += int'(ack_o[0]);
      end
      if (acks !== 4) begin
         errors++;
         $display("FAIL ovf_acks got %0d want 4", acks);
      end
      checks++;
   endtask

   task automatic test_full_simul();
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, mk((i == 0) ? 2'b01 : 2'b00, 8'h21, 32 + i), 2'b00);
      repeat (3) cyc(1'b0, 1'b0, 32'h0, 2'b00);
      for (int i = 0; i < 14; i++) begin
         if (i < 6) cyc(1'b1, 1'b0, mk((i == 5) ? 2'b10 : 2'b00, 8'h21, 64 + i), 2'b01);
         else       cyc(1'b0, 1'b0, 32'h0, 2'b01);
         if ({req_o, port_o, ack_o, lck_o, err_o} !== exp_ctl() || flit_o !== exp_flit()) begin
            errors++;
            $display("FAIL full_cyc i=%0d got %h/%h want %h/%h", i, {req_o, port_o, ack_o, lck_o, err_o}, flit_o, exp_ctl(), exp_flit());
         end
         checks++;
      end
      if (err_o !== 1'b0) begin
         errors++;
         $display("FAIL full_err got %b want 0", err_o);
      end
      checks++;
   endtask

   task automatic test_interleave();
      logic [1:0] ty [3] = '{2'b01, 2'b00, 2'b10};
      logic [4:0] p0 = 5'b0, p1 = 5'b0;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         if (i < 6) cyc(1'b1, 1'(i % 2), mk(ty[i/2], (i % 2) ? 8'h01 : 8'h10, 100 + i), 2'b11);
         else       cyc(1'b0, 1'b0, 32'h0, 2'b11);
         if ({req_o, port_o, ack_o, lck_o, err_o} !== exp_ctl() || flit_o !== exp_flit()) begin
            errors++;
            $display("FAIL ilv_cyc i=%0d got %h/%h want %h/%h", i, {req_o, port_o, ack_o, lck_o, err_o}, flit_o, exp_ctl(), exp_flit());
         end
         checks++;
         if (req_o[0]) p0 = port_o[4:0];
         if (req_o[1]) p1 = port_o[9:5];
      end
      if (p0 !== 5'b10000 || p1 !== 5'b01000) begin
         errors++;
         $display("FAIL ilv_ports got %b/%b want 10000/01000", p0, p1);
      end
      checks++;
   endtask

   task automatic test_orphan();
      int acks = 0;
      do_reset();
      cyc(1'b1, 1'b1, mk(2'b00, 8'h11, 200), 2'b00);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 32'h0, 2'b00);
         acks += int'(ack_o[1]);
      end
      if (acks !== 1 || err_o !== 1'b1 || lck_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL orphan got acks=%0d err=%b lck=%b want 1,1,0", acks, err_o, lck_o[1]);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      cyc(1'b1, 1'b0, mk(2'b01, 8'h12, 300), 2'b00);
      cyc(1'b1, 1'b0, mk(2'b00, 8'h12, 301), 2'b00);
      cyc(1'b0, 1'b0, 32'h0, 2'b00);
      cyc(1'b0, 1'b0, 32'h0, 2'b01);
      rst_n = 1'b0;
      #1;
      if ({req_o, port_o, ack_o, lck_o, err_o} !== 17'h0 || flit_o !== 64'h0) begin
         errors++;
         $display("FAIL rstmid got %h/%h want 0/0", {req_o, port_o, ack_o, lck_o, err_o}, flit_o);
      end
      checks++;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 32'h0, 2'b11);
         if ({req_o, port_o, ack_o, lck_o, err_o} !== exp_ctl()) begin
            errors++;
            $display("FAIL rstmid_after i=%0d got %h want %h", i, {req_o, port_o, ack_o, lck_o, err_o}, exp_ctl());
         end
         checks++;
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         d = mk(2'($urandom_range(0, 3)), {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))}, i);
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, 2'($urandom_range(0, 3)));
         if ({req_o, port_o, ack_o, lck_o, err_o} !== exp_ctl() || flit_o !== exp_flit()) begin
            errors++;
            $display("FAIL rand_cyc i=%0d got %h/%h want %h/%h", i, {req_o, port_o, ack_o, lck_o, err_o}, flit_o, exp_ctl(), exp_flit());
         end
         checks++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_headtail();
      test_packet_east();
      test_overflow();
      test_full_simul();
      test_interleave();
      test_orphan();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
